div_clk_meter: RTL and testbench
================================

# div_clk_meter

Measures an externally generated divided clock (e.g. the divide-by-7 output) against sys_clk. It reports period and high time in sys_clk cycles and flags lock when the period matches an expected ratio. It is the receive/check end of the clock-divider path: it sits beside the divider on the same sys_clk and validates its output in-system. The input is treated as asynchronous and synchronized internally.

## Interface
- CNT_W, 8: width of period/high-time counters and outputs.
- EXP_N, 7: expected period in sys_clk cycles for lock.
- LOCK_CNT, 4: consecutive matching periods required to assert locked (1..15).
- TIMEOUT, 200: cycles without a rising edge before timeout (must be < 2^CNT_W - 1).

Ports:
- sys_clk, input, 1: system clock, all logic on posedge.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- clk_in, input, 1: measured clock, asynchronous to sys_clk logic.
- enable, input, 1: measurement enable, level.
- period, output, CNT_W: last measured period, in sys_clk cycles.
- high_time, output, CNT_W: last measured high time, in sys_clk cycles.
- meas_valid, output, 1: one-cycle pulse when period/high_time update.
- meas_err, output, 1: one-cycle pulse, coincident with meas_valid, when period != EXP_N.
- locked, output, 1: level; LOCK_CNT consecutive periods equal EXP_N.
- timeout, output, 1: level; no rising edge for TIMEOUT cycles.

## Operation
- Synchronizer: 2 flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
- Counters:
  - p_cnt: cycles since last rise.
  - h_cnt: cycles since last rise while high.
  - Both saturate at 2^CNT_W - 1, with no wrap.
- FSM states: IDLE, SYNC, MEAS.
  - IDLE: entered on reset or enable=0. Counters cleared, match counter cleared. Goes to SYNC when enable=1.
  - SYNC: waits for the first rise. No output update. On rise: p_cnt<=1, h_cnt<=1, go to MEAS.
  - MEAS, each cycle: p_cnt++ (saturating).
  - MEAS, on fall: h_cnt frozen as the high time.
  - MEAS, on rise:
    - period<=p_cnt, high_time<=frozen h_cnt.
    - meas_valid<=1; meas_err<=(p_cnt!=EXP_N).
    - Restart: p_cnt<=1, h_cnt<=1.
- Period semantics: period equals the number of sys_clk cycles between consecutive rise detections. high_time equals the number of cycles from a rise detection to the following fall detection.
- Lock:
  - Match counter increments (saturating at LOCK_CNT) on each valid period == EXP_N.
  - locked=1 when the counter reaches LOCK_CNT.
  - A mismatch clears the counter and locked in the same update.
- Timeout:
  - In SYNC or MEAS, if no rise occurs and the cycles since the last rise (or since entering SYNC) reach TIMEOUT: timeout<=1, locked<=0, match counter<=0, go to SYNC.
  - timeout stays 1 until the next rise. The first rise after a timeout only restarts counting (no meas_valid); timeout clears on that rise.
- enable falling in any state: go to IDLE next cycle.
  - Any measurement in progress is discarded, with no meas_valid.
  - locked<=0 and timeout<=0.
  - period/high_time hold their last values.
- Reset values: period=0, high_time=0, meas_valid=0, meas_err=0, locked=0, timeout=0, state=IDLE, synchronizer flops=0.

## Timing
- clk_in edge to rise/fall detection: 2-3 sys_clk edges (synchronizer plus sampling uncertainty).
- Detection cycle to output update: outputs, meas_valid, meas_err and locked are registered and visible 1 cycle after the detection cycle.
- meas_valid is exactly 1 cycle wide. The minimum spacing between pulses is the measured period.
- Resolution is ±1 cycle.
  - For a 3.5-cycle high pulse, high_time reads 3 or 4.
  - For a stable integer-ratio input, period is exact.
- Simultaneous events:
  - A rise in the same cycle as the timeout threshold: the rise wins; a normal measurement, no timeout.
  - enable=0 in the same cycle as a rise: enable wins; no update.
- Saturated p_cnt can only occur if TIMEOUT is misconfigured. In that case it is reported as period = 2^CNT_W - 1 with meas_err=1.
- Asynchronous reset mid-measurement: all outputs return to reset values immediately. The next rise is treated as the first rise in SYNC.

## Test plan
- Connect the divide-by-7 output to clk_in, enable=1 -> first meas_valid on the second detected rise; every meas_valid shows period=7, high_time in {3,4}, meas_err=0; locked=1 with the 4th matching meas_valid.
- After lock, stretch one clk_in period to 9 cycles -> meas_valid with period=9, meas_err=1, locked=0 in the same cycle; re-locks after 4 further periods of 7.
- Hold clk_in low for 250 cycles -> timeout=1 exactly 200 cycles after the last rise detection, locked=0; on restart, the first rise clears timeout without meas_valid, and the next rise gives meas_valid.
- Deassert enable for 10 cycles mid-period -> no meas_valid, locked=0, period/high_time hold; after re-enable, the first meas_valid occurs on the second rise.
- Pulse sys_rst_n low mid-period while locked -> all outputs 0 immediately; measurement restarts cleanly and re-locks after LOCK_CNT+1 rises.
- Drive clk_in with period 7 and a 1-cycle high pulse, asynchronous phase -> period=7, high_time in {1,2}, no missed edges over 100 periods.

Source files
------------

// File: rtl/div_clk_meter.sv
// div_clk_meter: measures period and high time of an asynchronous divided
// clock in sys_clk cycles, flags lock on EXP_N and times out on a stuck input.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | disabled; counters, match count, lock and timeout cleared
// SYNC  | waiting for the first rise; no measurement is reported
// MEAS  | counting; each rise closes one period and reports it
module div_clk_meter #(
    parameter int CNT_W    = 8,
    parameter int EXP_N    = 7,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 200
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clk_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             meas_err,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_N);
    localparam logic [CNT_W-1:0] TMO_V   = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d, h_cnt_q, h_cnt_d;
    logic             h_frz_q, h_frz_d;
    logic [3:0]       match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d, meas_err_q, meas_err_d;
    logic             locked_q, locked_d, timeout_q, timeout_d;

    logic             rise, fall, tmo_hit, per_ok;
    logic [3:0]       match_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign rise      = s2_q & ~s3_q;
    assign fall      = ~s2_q & s3_q;
    // A rise in the threshold cycle takes priority, so it masks the timeout.
    assign tmo_hit   = ~rise & (p_cnt_q >= TMO_V);
    assign per_ok    = (p_cnt_q == EXP_V);
    assign match_inc = (match_q == LOCK_V) ? LOCK_V : match_q + 4'd1;

    // State, synchronizer and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            p_cnt_q      <= '0;
            h_cnt_q      <= '0;
            h_frz_q      <= 1'b0;
            match_q      <= 4'd0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            meas_err_q   <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            p_cnt_q      <= p_cnt_d;
            h_cnt_q      <= h_cnt_d;
            h_frz_q      <= h_frz_d;
            match_q      <= match_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            meas_err_q   <= meas_err_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic; dropping enable always wins over edges and timeout.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: if (rise) state_d = ST_MEAS;
                ST_MEAS: if (rise) state_d = ST_MEAS;
                         else if (tmo_hit) state_d = ST_SYNC;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counters, measurement outputs, lock and timeout.
    always_comb begin
        s1_d         = clk_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        p_cnt_d      = p_cnt_q;
        h_cnt_d      = h_cnt_q;
        h_frz_d      = h_frz_q;
        match_d      = match_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        meas_err_d   = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        if (!enable || state_q == ST_IDLE) begin
            p_cnt_d   = '0;
            h_cnt_d   = '0;
            h_frz_d   = 1'b0;
            match_d   = 4'd0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
        end else if (rise) begin
            // The first rise after SYNC only starts counting and clears timeout.
            p_cnt_d   = CNT_W'(1);
            h_cnt_d   = CNT_W'(1);
            h_frz_d   = 1'b0;
            timeout_d = 1'b0;
            if (state_q == ST_MEAS) begin
                period_d     = p_cnt_q;
                high_time_d  = h_cnt_q;
                meas_valid_d = 1'b1;
                meas_err_d   = ~per_ok;
                match_d      = per_ok ? match_inc : 4'd0;
                locked_d     = per_ok && (match_inc == LOCK_V);
            end
        end else if (tmo_hit) begin
            p_cnt_d   = '0;
            h_cnt_d   = '0;
            h_frz_d   = 1'b0;
            match_d   = 4'd0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
        end else begin
            p_cnt_d = sat_inc(p_cnt_q);
            // High time stops counting at the fall and stays frozen until the next rise.
            if (state_q == ST_MEAS && !(h_frz_q || fall)) h_cnt_d = sat_inc(h_cnt_q);
            if (fall) h_frz_d = 1'b1;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign meas_err   = meas_err_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_div_clk_meter.sv
// Bench for div_clk_meter: clk_in pulses are driven from tasks, the expected
// measurement for each closing rise is queued, and a monitor pops on meas_valid.
module tb_div_clk_meter;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       clk_in = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] period, high_time;
    logic       meas_valid, meas_err, locked, timeout;

    typedef struct {
        int per;
        int hmin;
        int hmax;
        bit err;
        bit lk;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   m = 0;
    int   prev_len = 0;
    int   prev_hi = 0;
    int   h_slack = 0;
    int   off = 1;
    bit   first_rise = 1'b1;

    div_clk_meter #(.CNT_W(8), .EXP_N(7), .LOCK_CNT(4), .TIMEOUT(200)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_in(clk_in), .enable(enable),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .meas_err(meas_err), .locked(locked), .timeout(timeout)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // Scoreboard monitor: every meas_valid must match the oldest queued expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (meas_valid === 1'b1) begin
            last_valid_cyc = cyc;
            n_assert++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_meas_valid: got meas_valid=1 at cycle %0d, required none", cyc);
            end else begin
                e = sb.pop_front();
                if (period !== 8'(e.per)) begin
                    n_fail++;
                    $display("FAIL sb_period: got %0d required %0d", period, e.per);
                end
                n_assert++;
                if (high_time < 8'(e.hmin) || high_time > 8'(e.hmax)) begin
                    n_fail++;
                    $display("FAIL sb_high_time: got %0d required %0d..%0d", high_time, e.hmin, e.hmax);
                end
                n_assert++;
                if (meas_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb_meas_err: got %b required %b", meas_err, e.err);
                end
                n_assert++;
                if (locked !== e.lk) begin
                    n_fail++;
                    $display("FAIL sb_locked: got %b required %b", locked, e.lk);
                end
            end
        end
    end

    // One clk_in pulse: high for hi cycles, low for lo cycles, edges at offset off.
    task automatic drive_pulse(input int hi, input int lo);
        exp_t e;
        @(posedge sys_clk);
        #(off);
        clk_in = 1'b1;
        if (!first_rise) begin
            if (prev_len == 7) m = (m < 4) ? m + 1 : 4;
            else m = 0;
            e.per  = prev_len;
            e.hmin = prev_hi;
            e.hmax = prev_hi + h_slack;
            e.err  = (prev_len != 7);
            e.lk   = (m == 4);
            sb.push_back(e);
        end
        first_rise = 1'b0;
        prev_len = hi + lo;
        prev_hi = hi;
        repeat (hi) @(posedge sys_clk);
        #(off);
        clk_in = 1'b0;
        repeat (lo - 1) @(posedge sys_clk);
    endtask

    task automatic restart_model();
        first_rise = 1'b1;
        m = 0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        enable = 1'b0;
        clk_in = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        n_assert++;
        if ({period, high_time, meas_valid, meas_err, locked, timeout} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {period, high_time, meas_valid, meas_err, locked, timeout});
        end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_assert++;
        if ({period, high_time, meas_valid, meas_err, locked, timeout} !== 20'd0) begin
            n_fail++;
            $display("FAIL post_reset_outputs: got %h required 0",
                     {period, high_time, meas_valid, meas_err, locked, timeout});
        end
    endtask

    task automatic test_lock();
        @(posedge sys_clk);
        #1 enable = 1'b1;
        repeat (2) @(posedge sys_clk);
        restart_model();
        for (int i = 0; i < 8; i++) drive_pulse(3, 4);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_level: got %b required 1", locked);
        end
    endtask

    task automatic test_stretch();
        drive_pulse(3, 6);
        for (int i = 0; i < 5; i++) drive_pulse(3, 4);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_after_stretch: got %b required 1", locked);
        end
    endtask

    task automatic test_timeout();
        int t_cyc = -1;
        for (int i = 0; i < 250; i++) begin
            @(negedge sys_clk);
            if (timeout === 1'b1 && t_cyc < 0) t_cyc = cyc;
        end
        n_assert++;
        if (t_cyc - last_valid_cyc != 200) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles (first seen %0d) required 200",
                     t_cyc - last_valid_cyc, t_cyc);
        end
        n_assert++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_locked: got %b required 0", locked);
        end
        n_assert++;
        if (timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_held: got %b required 1", timeout);
        end
        restart_model();
        drive_pulse(3, 4);
        @(negedge sys_clk);
        n_assert++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b required 0", timeout);
        end
        drive_pulse(3, 4);
        drive_pulse(3, 4);
    endtask

    task automatic test_enable();
        for (int i = 0; i < 5; i++) drive_pulse(3, 4);
        drive_pulse(3, 2);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_disable_locked: got %b required 1", locked);
        end
        @(posedge sys_clk);
        #1 enable = 1'b0;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_flags: got locked=%b timeout=%b required 0/0", locked, timeout);
        end
        n_assert++;
        if (period !== 8'd7 || high_time !== 8'd3) begin
            n_fail++;
            $display("FAIL disable_hold: got period=%0d high=%0d required 7/3", period, high_time);
        end
        @(posedge sys_clk);
        #1 enable = 1'b1;
        repeat (2) @(posedge sys_clk);
        restart_model();
        for (int i = 0; i < 6; i++) drive_pulse(3, 4);
    endtask

    task automatic test_async_reset();
        drive_pulse(3, 2);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        #1;
        n_assert++;
        if ({period, high_time, meas_valid, meas_err, locked, timeout} !== 20'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h required 0",
                     {period, high_time, meas_valid, meas_err, locked, timeout});
        end
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        restart_model();
        for (int i = 0; i < 6; i++) drive_pulse(3, 4);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_after_reset: got %b required 1", locked);
        end
    endtask

    task automatic test_async_phase();
        @(posedge sys_clk);
        #1 enable = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 enable = 1'b1;
        repeat (2) @(posedge sys_clk);
        off = $urandom_range(2, 8);
        h_slack = 1;
        restart_model();
        for (int i = 0; i < 101; i++) drive_pulse(1, 6);
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        n_assert++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL async_phase_locked: got %b required 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stretch();
        test_timeout();
        test_enable();
        test_async_reset();
        test_async_phase();
        repeat (10) @(posedge sys_clk);
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_meas_valid: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1);
    end

endmodule
